// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_sequencer
//  Description : Sequences one load/store from the MEM stage to a memory port
//                with wait states, misalignment abort and wait timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        load_instr,
    input  logic        size_byte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        mem_en,
    output logic        mem_rw,
    output logic        mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata
);

    // Counter holds 0..TIMEOUT-1; never narrower than 4 bits.
    localparam int CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    // Latched as "is write" so the reset value (0) reads as a read request.
    logic             write_q, write_d;
    logic             byte_q, byte_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      load_fmt;

    // Format the returned memory word for the latched load size and lane.
    always_comb begin
        load_fmt = mem_rdata;
        if (byte_q) begin
            case (addr_q[1:0])
                2'b00:   load_fmt = {24'h0, mem_rdata[7:0]};
                2'b01:   load_fmt = {24'h0, mem_rdata[15:8]};
                2'b10:   load_fmt = {24'h0, mem_rdata[23:16]};
                default: load_fmt = {24'h0, mem_rdata[31:24]};
            endcase
        end
    end

    // Next-state, request latch, wait counter and load capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        byte_d  = byte_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    write_d = ~load_instr;
                    byte_d  = size_byte;
                    if (!size_byte && (addr[1:0] != 2'b00)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    if (!write_q) rdata_d = load_fmt;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Ready takes priority over an expiring timeout.
                if (mem_ready) begin
                    if (!write_q) rdata_d = load_fmt;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            byte_q  <= byte_d;
            rdata_q <= rdata_d;
        end
    end

    // stall is gated by rst_n so a live req_valid cannot leak through reset.
    assign stall       = rst_n & (((state_q == S_IDLE) & req_valid) |
                                  (state_q == S_ACCESS) | (state_q == S_WAIT));
    assign mem_en      = (state_q == S_ACCESS) | (state_q == S_WAIT);
    assign mem_rw      = write_q;
    assign mem_size    = byte_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == S_DONE) & ~write_q;
    assign err         = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_sequencer
//  Description : Self-checking bench for mem_access_sequencer; expected load
//                results travel through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, load_instr, size_byte, mem_ready;
    logic [31:0] addr, wdata, mem_rdata;
    logic        stall, rdata_valid, err, mem_en, mem_rw, mem_size;
    logic [31:0] rdata, mem_addr, mem_wdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    // Per-access observations gathered by do_access.
    int          obs_stall, obs_en, obs_valid, obs_err;
    bit          obs_fin, obs_rw, obs_size, post_busy;
    logic [31:0] obs_rdata, obs_wdata, obs_addr, post_rdata;

    mem_access_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .load_instr(load_instr),
        .size_byte(size_byte), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .err(err), .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] exp_load(input bit byt, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * a[1:0]);
        return byt ? (sh & 32'h0000_00FF) : rd;
    endfunction

    // Drive one request; assert mem_ready on the ready_idx-th enabled cycle
    // (-1 = never). Live inputs are scrambled after the request cycle.
    task automatic do_access(input bit ld, input bit byt, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int ready_idx);
        int en_idx;
        en_idx = 0;
        obs_stall = 0; obs_en = 0; obs_valid = 0; obs_err = 0; obs_fin = 0;
        obs_rw = 0; obs_size = 0; obs_rdata = '0; obs_wdata = '0; obs_addr = '0;
        @(posedge clk); #1;
        req_valid = 1; load_instr = ld; size_byte = byt; addr = a; wdata = wd;
        mem_ready = 0; mem_rdata = 32'h0;
        for (int k = 0; k < 40 && !obs_fin; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                req_valid = 0; addr = ~a; wdata = ~wd; load_instr = ~ld; size_byte = ~byt;
                if (mem_en) begin
                    mem_ready = (en_idx == ready_idx);
                    mem_rdata = (en_idx == ready_idx) ? rd : (32'hBAD0_0000 | en_idx);
                    en_idx++;
                end else begin
                    mem_ready = 0;
                end
            end
            #4;
            if (stall) obs_stall++;
            if (mem_en) begin
                obs_en++; obs_wdata = mem_wdata; obs_rw = mem_rw;
                obs_size = mem_size; obs_addr = mem_addr;
            end
            if (rdata_valid) begin obs_valid++; obs_rdata = rdata; end
            if (err) obs_err++;
            if (k > 0 && !stall) obs_fin = 1;
        end
        @(posedge clk); #1;
        mem_ready = 0;
        #4;
        post_busy  = rdata_valid | err | mem_en | stall;
        post_rdata = rdata;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 1; load_instr = 0; size_byte = 1;
        addr = 32'h1234_5677; wdata = 32'hFFFF_FFFF; mem_rdata = 32'hFFFF_FFFF; mem_ready = 1;
        #3;
        n_cmp++; if ({stall, rdata_valid, err, mem_en, mem_rw, mem_size} !== 6'b0) begin n_bad++;
            $display("FAIL reset.ctrl: got %b want 000000", {stall, rdata_valid, err, mem_en, mem_rw, mem_size}); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset.rdata: got %h want 0", rdata); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_bad++;
            $display("FAIL reset.mem_bus: got %h %h want 0 0", mem_addr, mem_wdata); end
        @(posedge clk); @(posedge clk); #1;
        req_valid = 0; mem_ready = 0;
        #2 rst_n = 1;
    endtask

    task automatic test_word_load();
        exp_q.push_back(exp_load(0, 32'h100, 32'hDEAD_BEEF));
        do_access(1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        exp_v = exp_q.pop_front();
        n_cmp++; if (obs_stall !== 2) begin n_bad++; $display("FAIL word_load.stall: got %0d want 2", obs_stall); end
        n_cmp++; if (obs_valid !== 1) begin n_bad++; $display("FAIL word_load.valid: got %0d want 1", obs_valid); end
        n_cmp++; if (obs_rdata !== exp_v) begin n_bad++; $display("FAIL word_load.rdata: got %h want %h", obs_rdata, exp_v); end
        n_cmp++; if ({obs_rw, obs_addr} !== {1'b0, 32'h100}) begin n_bad++;
            $display("FAIL word_load.bus: got rw=%b addr=%h want rw=0 addr=00000100", obs_rw, obs_addr); end
        n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL word_load.post_idle: got busy=%b want 0", post_busy); end
        n_cmp++; if (post_rdata !== exp_v) begin n_bad++; $display("FAIL word_load.hold: got %h want %h", post_rdata, exp_v); end
    endtask

    task automatic test_byte_load_wait();
        exp_q.push_back(exp_load(1, 32'h103, 32'h1122_3344));
        do_access(1, 1, 32'h103, 32'h0, 32'h1122_3344, 3);
        exp_v = exp_q.pop_front();
        n_cmp++; if (obs_stall !== 5) begin n_bad++; $display("FAIL byte_load.stall: got %0d want 5", obs_stall); end
        n_cmp++; if (obs_en !== 4) begin n_bad++; $display("FAIL byte_load.en_cycles: got %0d want 4", obs_en); end
        n_cmp++; if (obs_rdata !== exp_v || obs_valid !== 1) begin n_bad++;
            $display("FAIL byte_load.rdata: got %h (valid %0d) want %h (valid 1)", obs_rdata, obs_valid, exp_v); end
    endtask

    task automatic test_stores();
        do_access(0, 1, 32'h40, 32'h0000_00A5, 32'h0, 0);
        n_cmp++; if (obs_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL byte_store.wdata: got %h want a5a5a5a5", obs_wdata); end
        n_cmp++; if ({obs_rw, obs_size} !== 2'b11) begin n_bad++;
            $display("FAIL byte_store.rw_size: got %b%b want 11", obs_rw, obs_size); end
        n_cmp++; if (obs_valid !== 0 || obs_err !== 0) begin n_bad++;
            $display("FAIL byte_store.pulses: got valid=%0d err=%0d want 0 0", obs_valid, obs_err); end
        n_cmp++; if (post_rdata !== 32'h0000_0011) begin n_bad++; $display("FAIL byte_store.rdata_hold: got %h want 00000011", post_rdata); end
        do_access(0, 0, 32'h80, 32'h1234_5678, 32'h0, 1);
        n_cmp++; if ({obs_wdata, obs_size, obs_addr} !== {32'h1234_5678, 1'b0, 32'h80}) begin n_bad++;
            $display("FAIL word_store.bus: got %h size=%b addr=%h want 12345678 size=0 addr=00000080", obs_wdata, obs_size, obs_addr); end
        n_cmp++; if (obs_stall !== 3) begin n_bad++; $display("FAIL word_store.stall: got %0d want 3", obs_stall); end
    endtask

    task automatic test_misaligned();
        do_access(1, 0, 32'h102, 32'h0, 32'hFFFF_FFFF, 0);
        n_cmp++; if (obs_en !== 0) begin n_bad++; $display("FAIL misaligned.mem_en: got %0d cycles want 0", obs_en); end
        n_cmp++; if (obs_err !== 1 || obs_valid !== 0) begin n_bad++;
            $display("FAIL misaligned.err: got err=%0d valid=%0d want 1 0", obs_err, obs_valid); end
        n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL misaligned.post_idle: got busy=%b want 0", post_busy); end
    endtask

    task automatic test_timeout();
        do_access(1, 0, 32'h300, 32'h0, 32'h5555_AAAA, -1);
        n_cmp++; if (obs_en !== 16) begin n_bad++; $display("FAIL timeout.en_cycles: got %0d want 16", obs_en); end
        n_cmp++; if (obs_err !== 1 || obs_valid !== 0) begin n_bad++;
            $display("FAIL timeout.err: got err=%0d valid=%0d want 1 0", obs_err, obs_valid); end
        n_cmp++; if (obs_stall !== 17) begin n_bad++; $display("FAIL timeout.stall: got %0d want 17", obs_stall); end
        n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL timeout.post_idle: got busy=%b want 0", post_busy); end
    endtask

    task automatic test_ready_on_timeout();
        exp_q.push_back(exp_load(0, 32'h304, 32'h0F0F_1234));
        do_access(1, 0, 32'h304, 32'h0, 32'h0F0F_1234, 15);
        exp_v = exp_q.pop_front();
        n_cmp++; if (obs_err !== 0 || obs_valid !== 1) begin n_bad++;
            $display("FAIL ready_timeout.pulses: got err=%0d valid=%0d want 0 1", obs_err, obs_valid); end
        n_cmp++; if (obs_rdata !== exp_v) begin n_bad++; $display("FAIL ready_timeout.rdata: got %h want %h", obs_rdata, exp_v); end
        n_cmp++; if (obs_en !== 16) begin n_bad++; $display("FAIL ready_timeout.en_cycles: got %0d want 16", obs_en); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_load(1, 32'h200 + i, 32'hA1B2_C3D4));
            do_access(1, 1, 32'h200 + i, 32'h0, 32'hA1B2_C3D4, i % 2);
            exp_v = exp_q.pop_front();
            n_cmp++; if (obs_rdata !== exp_v || obs_valid !== 1 || !obs_fin) begin n_bad++;
                $display("FAIL b2b.lane%0d: got %h (valid %0d fin %0d) want %h", i, obs_rdata, obs_valid, obs_fin, exp_v); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int bad_pulse;
        bad_pulse = 0;
        @(posedge clk); #1;
        req_valid = 1; load_instr = 1; size_byte = 0; addr = 32'h500; mem_ready = 0;
        @(posedge clk); #1; req_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        n_cmp++; if (mem_en !== 1'b1 || stall !== 1'b1) begin n_bad++;
            $display("FAIL rst_wait.pre: got mem_en=%b stall=%b want 1 1", mem_en, stall); end
        rst_n = 0; req_valid = 1;
        #1;
        n_cmp++; if ({mem_en, stall, err, rdata_valid} !== 4'b0) begin n_bad++;
            $display("FAIL rst_wait.immediate: got %b want 0000", {mem_en, stall, err, rdata_valid}); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (err || rdata_valid || mem_en || stall) bad_pulse++;
        end
        req_valid = 0;
        #1 rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (err || rdata_valid || mem_en || stall) bad_pulse++;
        end
        n_cmp++; if (bad_pulse !== 0) begin n_bad++; $display("FAIL rst_wait.no_pulse: got %0d busy samples want 0", bad_pulse); end
        exp_q.push_back(exp_load(0, 32'h600, 32'hCAFE_F00D));
        do_access(1, 0, 32'h600, 32'h0, 32'hCAFE_F00D, 0);
        exp_v = exp_q.pop_front();
        n_cmp++; if (obs_rdata !== exp_v || obs_valid !== 1 || obs_stall !== 2) begin n_bad++;
            $display("FAIL rst_wait.after: got %h valid=%0d stall=%0d want %h valid=1 stall=2", obs_rdata, obs_valid, obs_stall, exp_v); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load_wait();
        test_stores();
        test_misaligned();
        test_timeout();
        test_ready_on_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard.leftover: got %0d entries want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 The block SHALL have one parameter, TIMEOUT, default 15, giving the maximum number of wait cycles before an access is aborted.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port clk, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port req_valid, input, 1 bit: the MEM stage presents a load/store.
REQ-006 Port load_instr, input, 1 bit: 1 = load, 0 = store.
REQ-007 Port size_byte, input, 1 bit: 1 = byte access, 0 = word access.
REQ-008 Port addr, input, 32 bits: effective address.
REQ-009 Port wdata, input, 32 bits: store data.
REQ-010 Port mem_rdata, input, 32 bits: memory read data.
REQ-011 Port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-012 Port stall, output, 1 bit: freeze the pipeline at or before MEM.
REQ-013 Port rdata, output, 32 bits: load result.
REQ-014 Port rdata_valid, output, 1 bit: rdata is valid this cycle (single-cycle pulse).
REQ-015 Port err, output, 1 bit: access aborted (single-cycle pulse).
REQ-016 Port mem_en, output, 1 bit: memory request.
REQ-017 Port mem_rw, output, 1 bit: 1 = write, 0 = read.
REQ-018 Port mem_size, output, 1 bit: 1 = byte, 0 = word.
REQ-019 Port mem_addr, output, 32 bits: memory address.
REQ-020 Port mem_wdata, output, 32 bits: memory write data.

Function
REQ-021 The FSM SHALL have exactly five states: IDLE, ACCESS, WAIT, DONE, ERR.
REQ-022 In IDLE with req_valid=1, the block SHALL latch addr, wdata, load_instr and size_byte.
REQ-023 From IDLE with req_valid=1, the next state SHALL be ERR for a word access with addr[1:0]≠00 (misaligned), else ACCESS.
REQ-024 stall SHALL be 1 combinationally when (IDLE and req_valid) or state is ACCESS or WAIT, and 0 otherwise.
REQ-025 In ACCESS and WAIT, mem_en SHALL be 1 and mem_addr, mem_rw, mem_size and mem_wdata SHALL come from the latched request only, never from live inputs.
REQ-026 In IDLE, DONE and ERR, mem_en SHALL be 0.
REQ-027 In ACCESS, mem_ready=1 SHALL capture mem_rdata and go to DONE; otherwise the next state SHALL be WAIT with the wait counter cleared to 0.
REQ-028 In WAIT, mem_ready=1 SHALL capture mem_rdata and go to DONE.
REQ-029 In WAIT, if mem_ready=0 and the counter equals TIMEOUT-1, the next state SHALL be ERR; otherwise the counter SHALL increment (4-bit minimum width, no wrap before TIMEOUT).
REQ-030 mem_ready and the timeout condition in the same cycle SHALL resolve to DONE (ready wins).
REQ-031 DONE SHALL last one cycle, then go to IDLE, and SHALL ignore req_valid (the pipeline advances at the end of DONE).
REQ-032 In DONE, rdata_valid SHALL be 1 for loads and 0 for stores.
REQ-033 ERR SHALL last one cycle with err=1, rdata_valid=0 and stall=0, then go to IDLE.
REQ-034 For a word load, rdata SHALL equal the captured mem_rdata.
REQ-035 For a byte load, rdata SHALL be the zero-extended byte selected little-endian by addr[1:0] (00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24]).
REQ-036 For a byte store, mem_wdata SHALL be wdata[7:0] replicated in all four byte lanes; for a word store, mem_wdata SHALL be wdata.
REQ-037 rdata SHALL hold its last value outside DONE.
REQ-038 Minimum latency SHALL be: request in IDLE cycle N, ACCESS at N+1 with mem_ready=1, DONE at N+2 with stall=0.

Reset
REQ-039 While rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, counter=0, latched request=0, and all outputs to 0 (stall, rdata, rdata_valid, err, mem_en, mem_rw, mem_size, mem_addr, mem_wdata).
REQ-040 Reset asserted during ACCESS or WAIT SHALL drop mem_en in that same cycle and discard the access, with no rdata_valid or err pulse.

Verification
REQ-041 Word load, addr=0x100, mem_rdata=0xDEADBEEF, mem_ready=1 in ACCESS -> stall high for 2 cycles, DONE with rdata=0xDEADBEEF and rdata_valid=1.
REQ-042 Byte load, addr=0x103, mem_rdata=0x11223344, ready after 3 wait cycles -> rdata=0x00000011, stall high for 5 cycles.
REQ-043 Byte store, wdata=0x000000A5 -> mem_wdata=0xA5A5A5A5, mem_rw=1, mem_size=1, rdata_valid stays 0.
REQ-044 Word load, addr=0x102 -> no mem_en, err=1 for one cycle, then IDLE.
REQ-045 mem_ready held 0 with TIMEOUT=15 -> err pulse after 15 WAIT cycles; a separate case with mem_ready=1 exactly on the timeout cycle -> DONE, no err.
REQ-046 rst_n driven low mid-WAIT -> mem_en=0 and stall=0 immediately; after release, IDLE accepts a new request normally.
